// File: rtl/vmx_job_scheduler.sv
// Tile-job FIFO and sequencer for the VMX matrix-multiply wrapper: issues one job at a time,
// follows the wrapper phase flag, and recovers hung, faulted or aborted jobs via soft-clear.
module vmx_job_scheduler #(
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 64,
   parameter int CLR_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [7:0]  job_rbase,
   input  logic [7:0]  job_wbase,
   input  logic [3:0]  job_tag,
   input  logic        abort,
   output logic [7:0]  mm_rbase,
   output logic [7:0]  mm_wbase,
   output logic [31:0] mm_ctrl,
   input  logic [31:0] mm_flag,
   output logic        done_valid,
   output logic [3:0]  done_tag,
   output logic        done_err,
   output logic        busy,
   output logic [3:0]  q_level,
   output logic [15:0] jobs_done,
   output logic [7:0]  err_cnt
);
   localparam int PW = $clog2(QDEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int CW = $clog2(CLR_CYC + 1);
   localparam logic [31:0] CTRL_START = 32'h2;
   localparam logic [31:0] CTRL_CLEAR = 32'h1;

   typedef struct packed {
      logic [7:0] rbase;
      logic [7:0] wbase;
      logic [3:0] tag;
   } job_t;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RUN, S_CLEAR, S_RETIRE} state_t;

   job_t          mem [QDEPTH];
   job_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic [CW-1:0] clr_cnt;
   logic [3:0]    cur_tag;
   logic [2:0]    flag;
   logic          push, pop, flush, fault;
   logic          unused_flag_bits;

   assign flag             = mm_flag[2:0];
   assign unused_flag_bits = ^mm_flag[31:3];
   assign head             = mem[rd_ptr];
   assign job_ready        = (count != (PW+1)'(QDEPTH)) && !abort;
   assign push             = job_valid && job_ready;
   assign pop              = (state == S_RETIRE) && !abort;
   assign flush            = abort && (state == S_IDLE || state == S_RETIRE);
   assign q_level          = 4'(count);
   assign busy             = (state != S_IDLE);

   // Any fault during a live job (abort, illegal phase, or watchdog expiry) forces a soft-clear.
   assign fault = abort ||
                  ((state == S_WAIT || state == S_RUN) &&
                   (flag > 3'd4 || tmo_cnt == TW'(TIMEOUT - 1)));

   // NOTE: FIFO storage has no reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{rbase: job_rbase, wbase: job_wbase, tag: job_tag};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mm_rbase   <= '0;
         mm_wbase   <= '0;
         mm_ctrl    <= '0;
         done_valid <= 1'b0;
         done_tag   <= '0;
         done_err   <= 1'b0;
         jobs_done  <= '0;
         err_cnt    <= '0;
         tmo_cnt    <= '0;
         clr_cnt    <= '0;
         cur_tag    <= '0;
      end else begin
         // NOTE: pulse outputs default low each cycle so every set below lasts exactly one cycle.
         mm_ctrl    <= '0;
         done_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (count != '0 && !abort) begin
                  state    <= S_ISSUE;
                  mm_rbase <= head.rbase;
                  mm_wbase <= head.wbase;
                  cur_tag  <= head.tag;
                  mm_ctrl  <= CTRL_START;
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               if (fault) begin
                  state   <= S_CLEAR;
                  mm_ctrl <= CTRL_CLEAR;
                  clr_cnt <= '0;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT, S_RUN: begin
               if (fault) begin
                  state   <= S_CLEAR;
                  mm_ctrl <= CTRL_CLEAR;
                  clr_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
                  if (state == S_WAIT && flag != 3'd0) begin
                     state <= S_RUN;
                  end else if (state == S_RUN && flag == 3'd0) begin
                     state      <= S_RETIRE;
                     done_valid <= 1'b1;
                     done_tag   <= cur_tag;
                     done_err   <= 1'b0;
                  end
               end
            end
            S_CLEAR: begin
               if (clr_cnt == CW'(CLR_CYC - 1)) begin
                  state      <= S_RETIRE;
                  done_valid <= 1'b1;
                  done_tag   <= cur_tag;
                  done_err   <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + CW'(1);
                  mm_ctrl <= CTRL_CLEAR;
               end
            end
            S_RETIRE: begin
               state <= S_IDLE;
               if (done_err) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
               end else begin
                  jobs_done <= jobs_done + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vmx_job_scheduler.sv
// Scoreboard bench for vmx_job_scheduler with a behavioural wrapper model driving mm_flag.
module tb_vmx_job_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid;
   logic        job_ready;
   logic [7:0]  job_rbase;
   logic [7:0]  job_wbase;
   logic [3:0]  job_tag;
   logic        abort;
   logic [7:0]  mm_rbase;
   logic [7:0]  mm_wbase;
   logic [31:0] mm_ctrl;
   logic [31:0] mm_flag;
   logic        done_valid;
   logic [3:0]  done_tag;
   logic        done_err;
   logic        busy;
   logic [3:0]  q_level;
   logic [15:0] jobs_done;
   logic [7:0]  err_cnt;

   typedef enum {W_NORMAL, W_HANG, W_BAD} wmode_t;
   typedef struct {
      logic [3:0] tag;
      logic       err;
      logic [7:0] rb;
      logic [7:0] wb;
   } exp_t;

   exp_t   exp_q[$];
   wmode_t wmode = W_NORMAL;
   int     n_vec = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     start_cyc = 0;
   int     done_cyc = 0;
   logic [2:0] wflag;
   int     wcnt;

   vmx_job_scheduler dut (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
      .job_rbase(job_rbase), .job_wbase(job_wbase), .job_tag(job_tag), .abort(abort),
      .mm_rbase(mm_rbase), .mm_wbase(mm_wbase), .mm_ctrl(mm_ctrl), .mm_flag(mm_flag),
      .done_valid(done_valid), .done_tag(done_tag), .done_err(done_err), .busy(busy),
      .q_level(q_level), .jobs_done(jobs_done), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Wrapper model: start -> phases 1..4 for 16 cycles then IDLE; clear forces IDLE.
   assign mm_flag = {29'd0, wflag};
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wflag <= 3'd0;
         wcnt  <= 0;
      end else if (mm_ctrl[0]) begin
         wflag <= 3'd0;
         wcnt  <= 0;
      end else if (mm_ctrl[1]) begin
         wcnt <= 1;
         case (wmode)
            W_NORMAL: wflag <= 3'd1;
            W_BAD:    wflag <= 3'd7;
            default:  wflag <= 3'd0;
         endcase
      end else if (wmode == W_NORMAL && wflag != 3'd0) begin
         if (wcnt == 16) begin
            wflag <= 3'd0;
            wcnt  <= 0;
         end else begin
            wcnt  <= wcnt + 1;
            wflag <= 3'(wcnt / 4 + 1);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: start/clear pulse widths, start addresses, and every retire against the scoreboard.
   initial begin
      int   start_run = 0;
      int   clear_run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mm_ctrl == 32'h2) begin
               if (start_run == 0) begin
                  start_cyc = cyc;
                  if (exp_q.size() > 0) check("start_rbase", mm_rbase, exp_q[0].rb);
               end
               start_run++;
            end else if (start_run != 0) begin
               check("start_width", start_run, 1);
               start_run = 0;
            end
            if (mm_ctrl == 32'h1) begin
               clear_run++;
            end else if (clear_run != 0) begin
               check("clear_width", clear_run, 2);
               clear_run = 0;
            end
            if (done_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", done_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  done_cyc = cyc;
                  check("done_tag", done_tag, e.tag);
                  check("done_err", done_err, e.err);
                  check("done_rbase", mm_rbase, e.rb);
                  check("done_wbase", mm_wbase, e.wb);
               end
            end
         end
      end
   end

   task automatic push_job(input logic [7:0] rb, input logic [7:0] wb, input logic [3:0] tag,
                           input logic err, input bit expect_done);
      bit rdy = 1'b0;
      job_valid = 1'b1;
      job_rbase = rb;
      job_wbase = wb;
      job_tag   = tag;
      for (int i = 0; i < 200 && !rdy; i++) begin
         @(negedge clk);
         rdy = job_ready;
         @(posedge clk);
      end
      #1 job_valid = 1'b0;
      check("push_accept", rdy, 1);
      if (rdy && expect_done) exp_q.push_back('{tag: tag, err: err, rb: rb, wb: wb});
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = !busy && q_level == 4'd0 && exp_q.size() == 0 && !done_valid;
      end
      check("idle_reached", ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_flag(input logic [2:0] val);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = (mm_flag[2:0] == val);
      end
      check("flag_reached", ok, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      rst_n = 1'b0; job_valid = 1'b0; job_rbase = '0; job_wbase = '0; job_tag = '0; abort = 1'b0;
      #2;
      check("rst_mm_ctrl", mm_ctrl, 0);
      check("rst_busy", busy, 0);
      check("rst_q_level", q_level, 0);
      check("rst_job_ready", job_ready, 1);
      check("rst_done_valid", done_valid, 0);
      check("rst_jobs_done", jobs_done, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_mm_rbase", mm_rbase, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: single job, ideal wrapper.
      push_job(8'h10, 8'h40, 4'd3, 1'b0, 1'b1);
      wait_idle(100);
      check("t1_latency", done_cyc - start_cyc, 18);
      check("t1_jobs_done", jobs_done, 1);
      check("t1_err_cnt", err_cnt, 0);
      check("t1_q_level", q_level, 0);

      // 2: five back-to-back pushes into a 4-deep FIFO.
      for (int t = 0; t < 4; t++) push_job(8'(8'h20 + t), 8'(8'h60 + t), 4'(t), 1'b0, 1'b1);
      @(negedge clk);
      check("t2_q_full", q_level, 4);
      check("t2_ready_low", job_ready, 0);
      @(posedge clk); #1;
      push_job(8'h24, 8'h64, 4'd4, 1'b0, 1'b1);
      check("t2_push5_after_retire", jobs_done, 2);
      wait_idle(300);
      check("t2_jobs_done", jobs_done, 6);

      // 3: hung wrapper times out; the queued job then runs normally.
      wmode = W_HANG;
      push_job(8'h30, 8'h70, 4'd5, 1'b1, 1'b1);
      push_job(8'h31, 8'h71, 4'd6, 1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = (mm_ctrl == 32'h1);
      end
      check("t3_clear_seen", seen, 1);
      check("t3_timeout_cycles", cyc - start_cyc, 65);
      wmode = W_NORMAL;
      wait_idle(200);
      check("t3_err_cnt", err_cnt, 1);
      check("t3_jobs_done", jobs_done, 7);

      // 4: abort mid-RUN with a second job queued; held through the retire.
      push_job(8'h80, 8'h90, 4'd8, 1'b1, 1'b1);
      push_job(8'h81, 8'h91, 4'd9, 1'b0, 1'b0);
      wait_flag(3'd2);
      check("t4_q_level_pre", q_level, 2);
      @(posedge clk); #1 abort = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = done_valid;
         if (i == 0) check("t4_ready_abort", job_ready, 0);
      end
      check("t4_done_seen", seen, 1);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("t4_q_level", q_level, 0);
      check("t4_busy", busy, 0);
      check("t4_err_cnt", err_cnt, 2);
      check("t4_jobs_done", jobs_done, 7);
      @(posedge clk); #1;

      // 5: asynchronous reset in the middle of RUN.
      push_job(8'hA0, 8'hB0, 4'd10, 1'b0, 1'b1);
      wait_flag(3'd3);
      check("t5_busy_pre", busy, 1);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("t5_mm_ctrl", mm_ctrl, 0);
      check("t5_busy", busy, 0);
      check("t5_q_level", q_level, 0);
      check("t5_jobs_done", jobs_done, 0);
      check("t5_mm_rbase", mm_rbase, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_done", done_valid, 0);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // 6: push with abort in IDLE is dropped; an illegal flag forces an error retire.
      abort = 1'b1; job_valid = 1'b1; job_rbase = 8'hC0; job_wbase = 8'hD0; job_tag = 4'd11;
      @(negedge clk);
      check("t6_ready_low", job_ready, 0);
      @(posedge clk); #1 abort = 1'b0; job_valid = 1'b0;
      @(negedge clk);
      check("t6_q_level", q_level, 0);
      check("t6_busy", busy, 0);
      @(posedge clk); #1;
      wmode = W_BAD;
      push_job(8'hC1, 8'hD1, 4'd12, 1'b1, 1'b1);
      wait_idle(100);
      check("t6_err_cnt", err_cnt, 1);
      wmode = W_NORMAL;
      push_job(8'hC2, 8'hD2, 4'd13, 1'b0, 1'b1);
      wait_idle(100);
      check("t6_jobs_done", jobs_done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
